key_sw_ctrl: RTL
================

Name: key_sw_ctrl

Overview:
- Memory-mapped responder for the push-button (KEY) and slide-switch (SW) inputs on the processor's data-memory bus. The MEM stage is the bus initiator.
- Synchronizes and debounces the board pins, and exposes data and status/control registers.
- Sets sticky ready/overrun flags and raises an interrupt request.
- Read data is combinational, so the MEM stage can mux it into the load result in the same cycle as the access.

Parameters:
DBITS, 32, bus data/address width
KEYBITS, 4, number of KEY pins
SWBITS, 10, number of SW pins
DEBOUNCE_CYCLES, 50000, consecutive stable cycles (≥1) required before a new value is accepted
ADDRKDATA, 32'hFFFFF080, KEY data register
ADDRKCTRL, 32'hFFFFF084, KEY status/control register
ADDRSDATA, 32'hFFFFF090, SW data register
ADDRSCTRL, 32'hFFFFF094, SW status/control register

Ports:
clk  input  1  system clock (PLL output)
reset  input  1  synchronous, active-high reset
KEY  input  KEYBITS  raw push buttons, active-low (pressed = 0)
SW  input  SWBITS  raw slide switches, active-high
addr  input  DBITS  byte address from MEM stage
wdata  input  DBITS  store data
wr_en  input  1  store strobe, sampled at posedge
rd_en  input  1  load strobe, sampled at posedge, used only for side effects
rdata  output  DBITS  read data, combinational from addr
hit  output  1  addr equals one of the four register addresses
irq  output  1  interrupt request

Behaviour:
- Reset is synchronous on posedge clk with reset=1. Reset values:
  - KEY synchronizer flops = 1 (not pressed); SW synchronizer flops = 0.
  - Debounced values = 0; debounce counters = 0.
  - ready, ovr and ie = 0 in both groups; irq = 0.
  - Reset asserted mid-debounce discards the in-progress count.
- Synchronizer:
  - Two flops per pin (s1 then s2), plus a third flop s3 holding the previous s2.
  - KEY is inverted after s2, so pressed reads as 1.
- Debounce, per group, one counter each:
  - If s2 == debounced value, or s2 != s3: counter is cleared.
  - Otherwise the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES-1, the debounced value is loaded from s2 and the counter is cleared.
  - Result: a pin change held steady is visible in the data register exactly DEBOUNCE_CYCLES+3 edges after the pin changes.
  - A glitch shorter than DEBOUNCE_CYCLES cycles causes no change.
- Change event: asserted in the cycle where the debounced value loads a value different from the old one.
- KDATA / SDATA (read-only):
  - Debounced value, zero-extended to DBITS.
  - Writes are ignored.
  - A posedge with rd_en=1 and addr equal to the data address clears that group's ready bit.
- KCTRL / SCTRL register fields:
  - bit0 ready: read-only; set on a change event.
  - bit2 ovr: set on a change event while ready=1 and no same-cycle data read. A write with bit2=0 clears it; writing 1 is ignored.
  - bit8 ie: read/write.
  - All other bits read 0.
  - Reading a CTRL register has no side effects.
- Same-cycle priority, per group:
  - Change event and data read in the same cycle: ready ends at 1 (set wins) and ovr is unchanged.
  - Change event and write clearing ovr in the same cycle: ovr ends at 1 if the overrun condition holds.
- Bus decode:
  - Full DBITS address compare.
  - Unmapped address: rdata = 0, hit = 0, no effect.
  - wr_en and rd_en may both be 1: the write applies, and a read side effect applies only if addr is a data register.
- irq is registered: irq <= (k_ready & k_ie) | (s_ready & s_ie). It lags flag changes by one cycle.
- If SW is nonzero at reset release, a change event (SW ready=1) follows after debounce. This is intended.

Decomposition:
- Shared package holds:
  - the four ADDR* constants;
  - CTRL bit-index constants READY_BIT=0, OVR_BIT=2, IE_BIT=8;
  - KEYBITS and SWBITS.
- One sub-module, input_debouncer (parameterised width, DEBOUNCE_CYCLES, and synchronizer reset value):
  - contains synchronizer, counter, debounced value and change-event output;
  - instantiated once for KEY (after the inversion stage) and once for SW.
- Register and flag logic stays in key_sw_ctrl.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then read all four addresses with KEY=4'hF, SW=0 -> rdata=0 on every read, hit=1, irq=0; read addr 0xFFFFF088 -> rdata=0, hit=0.
- Drop KEY[1] to 0 and hold -> KDATA=0x2 exactly 7 edges later; KCTRL=0x1; read KDATA with rd_en -> KCTRL=0x0 next cycle.
- SW pulse 0->0x3FF for 3 cycles, then back to 0 -> SDATA stays 0 and SCTRL.ready stays 0.
- Write SCTRL=0x100; set SW=0x005 and hold -> SCTRL=0x101, irq=1 one cycle after ready; read SDATA -> irq=0 two cycles later.
- Two KEY changes with no intervening KDATA read -> KCTRL=0x5; write KCTRL=0x0 -> ovr cleared while ready remains 1 (KCTRL=0x1); writing 0x4 leaves ovr=1.
- KDATA read on the same edge as a change event -> ready=1 and ovr=0 afterwards; reset asserted mid-debounce -> counter cleared, KDATA=0, no change event.

Source files
------------

// File: rtl/key_sw_ctrl_pkg.sv
// Shared constants and types for the KEY/SW memory-mapped input controller.
// Register map, control-register bit positions and default pin counts live here.
package key_sw_ctrl_pkg;

    localparam int KEYBITS = 4;
    localparam int SWBITS  = 10;

    localparam logic [31:0] ADDRKDATA = 32'hFFFF_F080;
    localparam logic [31:0] ADDRKCTRL = 32'hFFFF_F084;
    localparam logic [31:0] ADDRSDATA = 32'hFFFF_F090;
    localparam logic [31:0] ADDRSCTRL = 32'hFFFF_F094;

    localparam int READY_BIT = 0;
    localparam int OVR_BIT   = 2;
    localparam int IE_BIT    = 8;

    localparam int NGROUPS = 2;
    localparam int GRP_KEY = 0;
    localparam int GRP_SW  = 1;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic ready;
    } ctrl_flags_t;

    // Places the flags at their architectural bit positions; all other bits read 0.
    function automatic logic [15:0] ctrl_word(input ctrl_flags_t f);
        logic [15:0] w;
        w            = '0;
        w[READY_BIT] = f.ready;
        w[OVR_BIT]   = f.ovr;
        w[IE_BIT]    = f.ie;
        return w;
    endfunction

endpackage

// File: rtl/key_sw_ctrl_debouncer.sv
// Two-flop synchronizer plus stability counter for one group of board pins.
// A new value is accepted only after it has been steady for DEBOUNCE_CYCLES cycles.
module input_debouncer #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] SYNC_RST        = '0,
    parameter bit               INVERT          = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] value_o,
    output logic             change_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s2_val;
    logic             stable, differs, load;

    // Active-low pins are flipped after the second flop so the rest sees pressed = 1.
    assign s2_val = INVERT ? ~s2_q : s2_q;

    always_comb begin
        stable  = (s2_q == s3_q);
        differs = (s2_val != deb_q);
        load    = stable && differs && (cnt_q == LAST);
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (!stable || !differs || load) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (load) begin
            deb_d = s2_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= SYNC_RST;
            s2_q  <= SYNC_RST;
            s3_q  <= SYNC_RST;
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= pins_i;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = deb_q;
    assign change_o = load;

endmodule

// File: rtl/key_sw_ctrl.sv
// Data-bus responder exposing debounced KEY/SW values plus ready/overrun/ie flags.
// Read data is combinational from addr; flags and irq update on the clock edge.
module key_sw_ctrl #(
    parameter int               DBITS           = 32,
    parameter int               KEYBITS         = key_sw_ctrl_pkg::KEYBITS,
    parameter int               SWBITS          = key_sw_ctrl_pkg::SWBITS,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [DBITS-1:0] ADDRKDATA       = key_sw_ctrl_pkg::ADDRKDATA,
    parameter logic [DBITS-1:0] ADDRKCTRL       = key_sw_ctrl_pkg::ADDRKCTRL,
    parameter logic [DBITS-1:0] ADDRSDATA       = key_sw_ctrl_pkg::ADDRSDATA,
    parameter logic [DBITS-1:0] ADDRSCTRL       = key_sw_ctrl_pkg::ADDRSCTRL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    input  logic [DBITS-1:0]   addr,
    input  logic [DBITS-1:0]   wdata,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [DBITS-1:0]   rdata,
    output logic               hit,
    output logic               irq
);
    import key_sw_ctrl_pkg::*;

    logic [KEYBITS-1:0] k_val;
    logic [SWBITS-1:0]  s_val;
    logic [NGROUPS-1:0] change, data_rd, ctrl_wr;
    ctrl_flags_t        flags [NGROUPS];
    logic               irq_q;
    logic               unused_wdata;

    input_debouncer #(
        .WIDTH           (KEYBITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_RST        ({KEYBITS{1'b1}}),
        .INVERT          (1'b1)
    ) u_key_db (
        .clk      (clk),
        .reset    (reset),
        .pins_i   (KEY),
        .value_o  (k_val),
        .change_o (change[GRP_KEY])
    );

    input_debouncer #(
        .WIDTH           (SWBITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_RST        ({SWBITS{1'b0}}),
        .INVERT          (1'b0)
    ) u_sw_db (
        .clk      (clk),
        .reset    (reset),
        .pins_i   (SW),
        .value_o  (s_val),
        .change_o (change[GRP_SW])
    );

    // Only data-register loads have a side effect; CTRL reads are pure.
    assign data_rd[GRP_KEY] = rd_en && (addr == ADDRKDATA);
    assign data_rd[GRP_SW]  = rd_en && (addr == ADDRSDATA);
    assign ctrl_wr[GRP_KEY] = wr_en && (addr == ADDRKCTRL);
    assign ctrl_wr[GRP_SW]  = wr_en && (addr == ADDRSCTRL);

    generate
        for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_flags
            ctrl_flags_t flags_q, flags_d;

            // A change event beats a same-cycle data read for ready, and an
            // overrun beats a same-cycle clearing write for ovr.
            always_comb begin
                flags_d = flags_q;
                if (change[gi]) begin
                    flags_d.ready = 1'b1;
                end else if (data_rd[gi]) begin
                    flags_d.ready = 1'b0;
                end
                if (ctrl_wr[gi]) begin
                    flags_d.ie = wdata[IE_BIT];
                    if (!wdata[OVR_BIT]) begin
                        flags_d.ovr = 1'b0;
                    end
                end
                if (change[gi] && flags_q.ready && !data_rd[gi]) begin
                    flags_d.ovr = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    flags_q <= '0;
                end else begin
                    flags_q <= flags_d;
                end
            end

            assign flags[gi] = flags_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (flags[GRP_KEY].ready & flags[GRP_KEY].ie)
                   | (flags[GRP_SW].ready & flags[GRP_SW].ie);
        end
    end

    assign irq = irq_q;

    always_comb begin
        rdata = '0;
        hit   = 1'b0;
        case (addr)
            ADDRKDATA: begin
                rdata = DBITS'(k_val);
                hit   = 1'b1;
            end
            ADDRKCTRL: begin
                rdata = DBITS'(ctrl_word(flags[GRP_KEY]));
                hit   = 1'b1;
            end
            ADDRSDATA: begin
                rdata = DBITS'(s_val);
                hit   = 1'b1;
            end
            ADDRSCTRL: begin
                rdata = DBITS'(ctrl_word(flags[GRP_SW]));
                hit   = 1'b1;
            end
            default: begin
                rdata = '0;
                hit   = 1'b0;
            end
        endcase
    end

    // Store data bits that map to no control field.
    assign unused_wdata = ^{wdata[DBITS-1:IE_BIT+1], wdata[IE_BIT-1:OVR_BIT+1],
                            wdata[OVR_BIT-1:0]};

endmodule
